axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_axis_rr_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Two-input AXI-Stream round-robin packet arbiter with a single registered output stage.
// A grant is held for a whole packet; per-port packet counters count accepted tlast beats.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int ID_WIDTH   = 8,
    parameter int DEST_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_1,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_1,
    input  logic                  s_axis_tvalid_1,
    output logic                  s_axis_tready_1,
    input  logic                  s_axis_tlast_1,
    input  logic [ID_WIDTH-1:0]   s_axis_tid_1,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest_1,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_2,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep_2,
    input  logic                  s_axis_tvalid_2,
    output logic                  s_axis_tready_2,
    input  logic                  s_axis_tlast_2,
    input  logic [ID_WIDTH-1:0]   s_axis_tid_2,
    input  logic [DEST_WIDTH-1:0] s_axis_tdest_2,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [ID_WIDTH-1:0]   m_axis_tid,
    output logic [DEST_WIDTH-1:0] m_axis_tdest,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_1,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_2
);

    typedef enum logic [1:0] {IDLE, GRANT1, GRANT2} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_last_grant2;  // 1 when port 2 owned the most recent packet
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [KEEP_WIDTH-1:0] r_tkeep;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [ID_WIDTH-1:0]   r_tid;
    logic [DEST_WIDTH-1:0] r_tdest;
    logic [CNT_WIDTH-1:0]  r_cnt_1;
    logic [CNT_WIDTH-1:0]  r_cnt_2;

    logic w_out_free;
    logic w_acc_1;
    logic w_acc_2;
    logic w_done_1;
    logic w_done_2;

    // Gating with rst keeps upstream from seeing an accept on the reset edge.
    assign w_out_free      = !r_tvalid || m_axis_tready;
    assign s_axis_tready_1 = !rst && (r_state == GRANT1) && w_out_free;
    assign s_axis_tready_2 = !rst && (r_state == GRANT2) && w_out_free;
    assign w_acc_1         = s_axis_tvalid_1 && s_axis_tready_1;
    assign w_acc_2         = s_axis_tvalid_2 && s_axis_tready_2;
    assign w_done_1        = w_acc_1 && s_axis_tlast_1;
    assign w_done_2        = w_acc_2 && s_axis_tlast_2;

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (s_axis_tvalid_1 && (!s_axis_tvalid_2 || r_last_grant2))
                    w_state_next = GRANT1;
                else if (s_axis_tvalid_2)
                    w_state_next = GRANT2;
            end
            GRANT1:  if (w_done_1) w_state_next = IDLE;
            GRANT2:  if (w_done_2) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_last_grant2 <= 1'b1;
            r_cnt_1       <= '0;
            r_cnt_2       <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_done_1) begin
                r_last_grant2 <= 1'b0;
                r_cnt_1       <= r_cnt_1 + 1'b1;
            end
            if (w_done_2) begin
                r_last_grant2 <= 1'b1;
                r_cnt_2       <= r_cnt_2 + 1'b1;
            end
        end
    end

    // NOTE: payload registers are reset too, so a discarded beat never leaks out after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tkeep  <= '0;
            r_tlast  <= 1'b0;
            r_tid    <= '0;
            r_tdest  <= '0;
        end else if (w_acc_1) begin
            r_tvalid <= 1'b1;
            r_tdata  <= s_axis_tdata_1;
            r_tkeep  <= s_axis_tkeep_1;
            r_tlast  <= s_axis_tlast_1;
            r_tid    <= s_axis_tid_1;
            r_tdest  <= s_axis_tdest_1;
        end else if (w_acc_2) begin
            r_tvalid <= 1'b1;
            r_tdata  <= s_axis_tdata_2;
            r_tkeep  <= s_axis_tkeep_2;
            r_tlast  <= s_axis_tlast_2;
            r_tid    <= s_axis_tid_2;
            r_tdest  <= s_axis_tdest_2;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tkeep  = r_tkeep;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tid    = r_tid;
    assign m_axis_tdest  = r_tdest;
    assign grant         = {r_state == GRANT2, r_state == GRANT1};
    assign pkt_cnt_1     = r_cnt_1;
    assign pkt_cnt_2     = r_cnt_2;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: arbitration vector table, scoreboard of
// accepted beats, and directed sequences for latency, fairness, stalls, bubbles, reset and wrap.
module tb_axis_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_tdata_1, s_tdata_2, m_tdata;
    logic [7:0]  s_tkeep_1, s_tkeep_2, m_tkeep;
    logic        s_tvalid_1, s_tvalid_2, m_tvalid;
    logic        s_tready_1, s_tready_2, m_tready;
    logic        s_tlast_1, s_tlast_2, m_tlast;
    logic [7:0]  s_tid_1, s_tid_2, m_tid;
    logic [7:0]  s_tdest_1, s_tdest_2, m_tdest;
    logic [1:0]  grant;
    logic [3:0]  pkt_cnt_1, pkt_cnt_2;

    axis_rr_arbiter #(.CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata_1(s_tdata_1), .s_axis_tkeep_1(s_tkeep_1), .s_axis_tvalid_1(s_tvalid_1),
        .s_axis_tready_1(s_tready_1), .s_axis_tlast_1(s_tlast_1), .s_axis_tid_1(s_tid_1),
        .s_axis_tdest_1(s_tdest_1),
        .s_axis_tdata_2(s_tdata_2), .s_axis_tkeep_2(s_tkeep_2), .s_axis_tvalid_2(s_tvalid_2),
        .s_axis_tready_2(s_tready_2), .s_axis_tlast_2(s_tlast_2), .s_axis_tid_2(s_tid_2),
        .s_axis_tdest_2(s_tdest_2),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .grant(grant), .pkt_cnt_1(pkt_cnt_1), .pkt_cnt_2(pkt_cnt_2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [7:0]  id;
        logic [7:0]  dest;
    } beat_t;

    typedef struct {
        logic       v1;
        logic       v2;
        logic [1:0] exp_grant;
        logic [3:0] exp_c1;
        logic [3:0] exp_c2;
    } arb_vec_t;

    beat_t      exp_q[$];
    logic [7:0] out_tid[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         n_out = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: inputs change #1 after posedge, so at negedge a handshake seen here
    // is the one that completes at the next posedge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (m_tvalid && m_tready) begin
                n_out++;
                out_tid.push_back(m_tid);
                if (exp_q.size() == 0)
                    check("sb_unexpected_beat", {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest}, '1);
                else
                    check("sb_beat", {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest}, exp_q.pop_front());
            end
            if (s_tvalid_1 && s_tready_1)
                exp_q.push_back('{s_tdata_1, s_tkeep_1, s_tlast_1, s_tid_1, s_tdest_1});
            if (s_tvalid_2 && s_tready_2)
                exp_q.push_back('{s_tdata_2, s_tkeep_2, s_tlast_2, s_tid_2, s_tdest_2});
        end
    end

    task automatic set_port(input int p, input logic v, input logic [7:0] tag,
                            input logic [7:0] idx, input logic last);
        if (p == 1) begin
            s_tvalid_1 = v; s_tdata_1 = {48'h0, tag, idx}; s_tkeep_1 = 8'h0F;
            s_tlast_1 = last; s_tid_1 = 8'd1; s_tdest_1 = tag;
        end else begin
            s_tvalid_2 = v; s_tdata_2 = {48'h0, tag, idx}; s_tkeep_2 = 8'hF0;
            s_tlast_2 = last; s_tid_2 = 8'd2; s_tdest_2 = tag;
        end
    endtask

    function automatic logic rdy(input int p);
        return (p == 1) ? s_tready_1 : s_tready_2;
    endfunction

    task automatic wait_rdy(input int p);
        int w = 0;
        @(negedge clk);
        while (!rdy(p)) begin
            if (w == 200) begin
                n_vec++;
                n_err++;
                $display("FAIL wait_rdy_port%0d: tready=0 after %0d cycles, expected 1", p, w);
                return;
            end
            w++;
            @(negedge clk);
        end
    endtask

    task automatic drive_port(input int p, input int npkts, input int nbeats, input logic [7:0] tag,
                              input int gap_at, input int gap_len);
        for (int pk = 0; pk < npkts; pk++) begin
            for (int b = 0; b < nbeats; b++) begin
                set_port(p, 1'b1, tag + 8'(pk), 8'(b), b == nbeats - 1);
                wait_rdy(p);
                @(posedge clk); #1;
                if (gap_len > 0 && b == gap_at) begin
                    set_port(p, 1'b0, 8'h0, 8'h0, 1'b0);
                    repeat (gap_len) @(posedge clk);
                    #1;
                end
            end
        end
        set_port(p, 1'b0, 8'h0, 8'h0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        m_tready = 1'b1;
        set_port(1, 1'b0, 8'h0, 8'h0, 1'b0);
        set_port(2, 1'b0, 8'h0, 8'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_tid.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    arb_vec_t tbl[8];
    beat_t    held;
    int       viol;
    int       w;
    int       out_base;
    logic [7:0] exp_order[8];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 2'b01, 4'd1, 4'd0};
        tbl[1] = '{1'b1, 1'b1, 2'b10, 4'd1, 4'd1};
        tbl[2] = '{1'b1, 1'b0, 2'b01, 4'd2, 4'd1};
        tbl[3] = '{1'b1, 1'b0, 2'b01, 4'd3, 4'd1};
        tbl[4] = '{1'b1, 1'b1, 2'b10, 4'd3, 4'd2};
        tbl[5] = '{1'b0, 1'b1, 2'b10, 4'd3, 4'd3};
        tbl[6] = '{1'b1, 1'b1, 2'b01, 4'd4, 4'd3};
        tbl[7] = '{1'b0, 1'b0, 2'b00, 4'd4, 4'd3};
        exp_order = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2};

        rst = 1'b0;
        m_tready = 1'b1;
        set_port(1, 1'b0, 8'h0, 8'h0, 1'b0);
        set_port(2, 1'b0, 8'h0, 8'h0, 1'b0);

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_fields", {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest}, 0);
        check("rst_grant", grant, 0);
        check("rst_cnts", {pkt_cnt_1, pkt_cnt_2}, 0);
        check("rst_treadys", {s_tready_1, s_tready_2}, 0);

        // Arbitration table: single-beat packets presented in IDLE
        for (int r = 0; r < 8; r++) begin
            @(posedge clk); #1;
            set_port(1, tbl[r].v1, 8'h10 + 8'(r), 8'h00, 1'b1);
            set_port(2, tbl[r].v2, 8'h20 + 8'(r), 8'h00, 1'b1);
            @(posedge clk);
            @(negedge clk);
            check($sformatf("tbl%0d_grant", r), grant, tbl[r].exp_grant);
            check($sformatf("tbl%0d_treadys", r), {s_tready_2, s_tready_1}, tbl[r].exp_grant);
            @(posedge clk); #1;
            set_port(1, 1'b0, 8'h0, 8'h0, 1'b0);
            set_port(2, 1'b0, 8'h0, 8'h0, 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d_cnts", r), {pkt_cnt_1, pkt_cnt_2}, {tbl[r].exp_c1, tbl[r].exp_c2});
        end
        idle(3);
        check("tbl_sb_empty", exp_q.size(), 0);

        // Single requester, latency t+2..t+4
        do_reset();
        @(posedge clk); #1;
        set_port(1, 1'b1, 8'h00, 8'hA0, 1'b0);
        @(negedge clk);
        check("lat_t0_grant", grant, 2'b00);
        check("lat_t0_tready1", s_tready_1, 0);
        @(posedge clk); @(negedge clk);
        check("lat_t1_grant", grant, 2'b01);
        check("lat_t1_tready1", s_tready_1, 1);
        @(posedge clk); #1;
        set_port(1, 1'b1, 8'h00, 8'hA1, 1'b0);
        @(negedge clk);
        check("lat_t2_beat", {m_tvalid, m_tdata}, {1'b1, 64'hA0});
        @(posedge clk); #1;
        set_port(1, 1'b1, 8'h00, 8'hA2, 1'b1);
        @(negedge clk);
        check("lat_t3_beat", {m_tvalid, m_tdata}, {1'b1, 64'hA1});
        @(posedge clk); #1;
        set_port(1, 1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        check("lat_t4_beat", {m_tvalid, m_tlast, m_tdata}, {2'b11, 64'hA2});
        check("lat_t4_grant_cnt", {grant, pkt_cnt_1}, {2'b00, 4'd1});
        @(posedge clk); @(negedge clk);
        check("lat_t5_tvalid", m_tvalid, 0);

        // Fairness: both ports stream 2-beat packets
        do_reset();
        fork
            drive_port(1, 2, 2, 8'h40, 0, 0);
            drive_port(2, 2, 2, 8'h50, 0, 0);
        join
        idle(3);
        check("fair_nbeats", out_tid.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("fair_order%0d", i), (i < out_tid.size()) ? out_tid[i] : 8'hXX, exp_order[i]);
        check("fair_cnts", {pkt_cnt_1, pkt_cnt_2}, {4'd2, 4'd2});

        // Backpressure for 5 cycles mid-packet
        do_reset();
        out_base = n_out;
        fork
            drive_port(1, 1, 4, 8'h60, 0, 0);
            begin
                w = 0;
                do begin
                    @(negedge clk);
                    w++;
                end while (!m_tvalid && w < 50);
                @(posedge clk); #1;
                m_tready = 1'b0;
                @(negedge clk);
                held = {m_tdata, m_tkeep, m_tlast, m_tid, m_tdest};
                check("bp_c0_hold", {m_tvalid, s_tready_1}, 2'b10);
                for (int i = 1; i < 5; i++) begin
                    @(posedge clk); @(negedge clk);
                    check($sformatf("bp_c%0d_hold", i),
                          {m_tvalid, s_tready_1, m_tdata, m_tkeep, m_tlast, m_tid, m_tdest},
                          {2'b10, held});
                end
                @(posedge clk); #1;
                m_tready = 1'b1;
            end
        join
        idle(4);
        check("bp_nbeats", n_out - out_base, 4);
        check("bp_sb_empty", exp_q.size(), 0);

        // Bubble: port 1 idles 3 cycles mid-packet while port 2 waits
        do_reset();
        viol = 0;
        fork
            drive_port(1, 1, 4, 8'h70, 1, 3);
            drive_port(2, 1, 2, 8'h80, 0, 0);
            begin
                w = 0;
                while (pkt_cnt_1 != 4'd1 && w < 100) begin
                    @(negedge clk);
                    if (s_tready_2) viol++;
                    w++;
                end
            end
        join
        idle(3);
        check("bubble_tready2_viol", viol, 0);
        check("bubble_order", {out_tid.size() == 6 ? {out_tid[0], out_tid[3], out_tid[4]} : 24'hX},
              {8'd1, 8'd1, 8'd2});
        check("bubble_sb_empty", exp_q.size(), 0);

        // Reset mid-packet with the output stalled
        do_reset();
        drive_port(1, 1, 1, 8'h90, 0, 0);
        idle(3);
        set_port(1, 1'b1, 8'h91, 8'h00, 1'b0);
        wait_rdy(1);
        @(posedge clk); #1;
        set_port(1, 1'b1, 8'h91, 8'h01, 1'b0);
        m_tready = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_tready = 1'b1;
        set_port(1, 1'b0, 8'h0, 8'h0, 1'b0);
        @(negedge clk);
        check("mrst_tvalid", m_tvalid, 0);
        check("mrst_grant", grant, 0);
        check("mrst_cnts", {pkt_cnt_1, pkt_cnt_2}, 0);
        out_tid.delete();
        fork
            drive_port(1, 1, 1, 8'hA8, 0, 0);
            drive_port(2, 1, 1, 8'hB8, 0, 0);
        join
        idle(3);
        check("mrst_tie_order", out_tid.size() == 2 ? {out_tid[0], out_tid[1]} : 16'hX, {8'd1, 8'd2});

        // Counter wrap with CNT_WIDTH=4
        do_reset();
        drive_port(2, 17, 1, 8'hC0, 0, 0);
        idle(3);
        check("wrap_cnt2", pkt_cnt_2, 4'd1);
        check("wrap_cnt1", pkt_cnt_1, 4'd0);
        check("wrap_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
